axi_abr_if: RTL and testbench
=============================

AXI_ABR_IF -- requirements
Module: axi_abr_if

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI transaction ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 128, R data width (fixed 128; size code 4).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 a_valid  input  1  address-channel valid.
REQ-007 a_ready  output  1  address-channel ready.
REQ-008 a_write  input  1  1 = write (AW), 0 = read (AR).
REQ-009 a_id  input  ID_WIDTH  transaction ID.
REQ-010 a_addr  input  ADDR_WIDTH  start byte address.
REQ-011 a_len  input  8  beats minus one.
REQ-012 a_size  input  3  log2 bytes per beat.
REQ-013 a_burst  input  2  00 FIXED, 01 INCR, 10 WRAP.
REQ-014 b_valid / b_ready  output / input  1 each  write-response handshake.
REQ-015 b_id  output  ID_WIDTH; b_resp  output  2  write-response ID and status.
REQ-016 r_valid / r_ready  output / input  1 each  read-data handshake.
REQ-017 r_id  output  ID_WIDTH; r_data  output  DATA_WIDTH; r_resp  output  2; r_last  output  1.

Function
REQ-018 SHALL implement FSM with states IDLE, BRESP and RDATA, and SHALL accept one transaction at a time.
REQ-019 a_ready SHALL be 1 only in IDLE; A handshake = a_valid && a_ready.
REQ-020 Write handshake: SHALL capture a_id, go to BRESP, and assert b_valid the next cycle with b_id = a_id.
REQ-021 BRESP: b_valid, b_id and b_resp SHALL hold stable until b_ready; on b_valid && b_ready, return to IDLE (a_ready = 1 the following cycle).
REQ-022 Read handshake: SHALL capture ID/addr/len/size/burst, go to RDATA, and present beat 0 the next cycle.
REQ-023 RDATA: SHALL emit a_len+1 beats; a beat advances only on r_valid && r_ready; outputs stay stable while r_valid && !r_ready.
REQ-024 r_last SHALL be 1 only on the final beat; len=0 gives a single beat with r_last = 1; after the last handshake, return to IDLE.
REQ-025 Beat address SHALL be: INCR and WRAP: start + n*2^a_size; FIXED: start.
REQ-026 Beat-address arithmetic SHALL truncate modulo 2^ADDR_WIDTH (wrap-around at top of address space).
REQ-027 r_data SHALL be the beat address zero-extended to 32 bits, replicated four times across 128 bits.
REQ-028 r_id SHALL equal the captured ID on every beat.
REQ-029 r_resp and b_resp SHALL be 2'b00 (OKAY) unless REQ-036 applies.
REQ-030 a_valid SHALL be ignored outside IDLE; b_ready and r_ready SHALL be ignored when the matching valid is low.

Reset
REQ-031 rst SHALL force IDLE on the next edge and abort any in-flight transaction without completing it.
REQ-032 Reset values SHALL be: a_ready 0 while rst is high, then 1 after release; b_valid 0, r_valid 0, r_last 0; b_id, r_id, r_data, b_resp, r_resp all 0.

Configuration
REQ-033 Macro AXI_RESP_CHECK_EN SHALL enable a protocol-check feature.
REQ-034 Without AXI_RESP_CHECK_EN, every response SHALL be OKAY.
REQ-035 Without AXI_RESP_CHECK_EN, WRAP SHALL behave as INCR.
REQ-036 With AXI_RESP_CHECK_EN, a transaction with a_size != 3'd4 or a_burst != 2'b01 SHALL return SLVERR (2'b10).
REQ-037 SLVERR SHALL go on the single B response (write) or on every R beat (read); beat count and timing SHALL be unchanged.

Verification
REQ-038 Write addr 0, id 0, len 1, size 4, INCR -> b_valid one cycle after handshake, b_id 0, b_resp 00; a_ready 1 after b handshake.
REQ-039 Read addr 0, len 1, size 4 -> beat 0 r_data {4{32'h00000000}} r_last 0; beat 1 {4{32'h00000010}} r_last 1; r_id 0, r_resp 00.
REQ-040 Read addr 32, same params -> r_data {4{32'h20}} then {4{32'h30}}; r_last 0 then 1.
REQ-041 Read len 3 with r_ready low 3 cycles mid-burst -> outputs stable while stalled; exactly 4 beats total; a_valid asserted during burst is not accepted.
REQ-042 Read addr 32'hFFFFFFF0, len 1, INCR -> second beat address 32'h00000000.
REQ-043 With AXI_RESP_CHECK_EN, read FIXED burst -> both beats r_resp 10; without it -> 00. Assert rst mid-burst -> r_valid 0 next cycle, then IDLE.

Source files
------------

// File: rtl/axi_abr_if.sv
// axi_abr_if: single-outstanding AXI slave returning beat addresses as read data; AXI_RESP_CHECK_EN flags non-128-bit/non-INCR bursts as SLVERR
module axi_abr_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_write,
  input  logic [ID_WIDTH-1:0]   a_id,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [7:0]            a_len,
  input  logic [2:0]            a_size,
  input  logic [1:0]            a_burst,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last
);
  localparam logic [1:0] IDLE = 2'd0, BRESP = 2'd1, RDATA = 2'd2;
  logic [1:0]            state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            cnt;
  logic [2:0]            size_q;
  logic                  fixed_q;
  logic [1:0]            resp_q, resp_n;
`ifdef AXI_RESP_CHECK_EN
  assign resp_n = (a_size != 3'd4 || a_burst != 2'b01) ? 2'b10 : 2'b00;
`else
  assign resp_n = 2'b00;
`endif
  assign a_ready = state == IDLE && !rst;
  assign b_valid = state == BRESP;
  assign b_id    = id_q;
  assign b_resp  = resp_q;
  assign r_valid = state == RDATA;
  assign r_id    = id_q;
  assign r_resp  = resp_q;
  assign r_last  = r_valid && cnt == 8'd0;
  assign r_data  = DATA_WIDTH'({4{32'(addr_q)}});
  // addr_q holds the current beat address; WRAP advances like INCR
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      cnt     <= '0;
      size_q  <= '0;
      fixed_q <= 1'b0;
      resp_q  <= 2'b00;
    end else if (state == IDLE) begin
      if (a_valid) begin
        id_q   <= a_id;
        resp_q <= resp_n;
        state  <= a_write ? BRESP : RDATA;
        if (!a_write) begin
          addr_q  <= a_addr;
          cnt     <= a_len;
          size_q  <= a_size;
          fixed_q <= a_burst == 2'b00;
        end
      end
    end else if (state == BRESP) begin
      if (b_ready) state <= IDLE;
    end else if (state == RDATA) begin
      if (r_ready) begin
        state  <= cnt == 8'd0 ? IDLE : RDATA;
        cnt    <= cnt - 8'd1;
        addr_q <= fixed_q ? addr_q : addr_q + (ADDR_WIDTH'(1) << size_q);
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_axi_abr_if.sv
// tb_axi_abr_if: directed checks of write response, read bursts, stalls, address wrap and reset abort
module tb_axi_abr_if;
  logic         clk = 1'b0, rst = 1'b1;
  logic         a_valid = 1'b0, a_write = 1'b0, b_ready = 1'b0, r_ready = 1'b0;
  logic [3:0]   a_id = '0;
  logic [31:0]  a_addr = '0;
  logic [7:0]   a_len = '0;
  logic [2:0]   a_size = '0;
  logic [1:0]   a_burst = '0;
  logic         a_ready, b_valid, r_valid, r_last;
  logic [3:0]   b_id, r_id;
  logic [1:0]   b_resp, r_resp;
  logic [127:0] r_data;
  int checks = 0, errors = 0;
`ifdef AXI_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  axi_abr_if dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write),
    .a_id(a_id), .a_addr(a_addr), .a_len(a_len), .a_size(a_size), .a_burst(a_burst),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [1:0] exp_resp(input logic [2:0] size, input logic [1:0] burst);
    return (CHK && (size != 3'd4 || burst != 2'b01)) ? 2'b10 : 2'b00;
  endfunction
  task automatic issue(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    a_valid = 1'b1; a_write = wr; a_id = id; a_addr = addr; a_len = len; a_size = size; a_burst = burst;
    check("a_ready_before", a_ready, 1);
    step();
    a_valid = 1'b0; a_id = 4'hF; a_addr = 32'hDEAD_BEEF;
  endtask
  task automatic wr(input logic [3:0] id, input logic [2:0] size, input logic [1:0] burst, input int stall);
    issue(1'b1, id, 32'h0, 8'd1, size, burst);
    b_ready = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      check("b_valid", b_valid, 1);
      check("b_id", b_id, id);
      check("b_resp", b_resp, exp_resp(size, burst));
      check("a_ready_bresp", a_ready, 0);
      if (i < stall) step();
    end
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    check("b_valid_done", b_valid, 0);
    check("a_ready_after_b", a_ready, 1);
  endtask
  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
    logic [31:0] e;
    issue(1'b0, id, addr, len, size, burst);
    r_ready = 1'b1;
    for (int n = 0; n <= int'(len); n++) begin
      e = (burst == 2'b00) ? addr : addr + (32'(n) << size);
      check("r_valid", r_valid, 1);
      check("r_data", r_data, {4{e}});
      check("r_last", r_last, n == int'(len));
      check("r_id", r_id, id);
      check("r_resp", r_resp, exp_resp(size, burst));
      if (n == stall_beat) begin
        r_ready = 1'b0;
        a_valid = 1'b1; a_write = 1'b1;
        for (int s = 0; s < 3; s++) begin
          step();
          check("stall_valid", r_valid, 1);
          check("stall_data", r_data, {4{e}});
          check("stall_last", r_last, n == int'(len));
          check("stall_a_ready", a_ready, 0);
        end
        a_valid = 1'b0;
        r_ready = 1'b1;
      end
      step();
    end
    r_ready = 1'b0;
    check("r_valid_done", r_valid, 0);
    check("a_ready_after_r", a_ready, 1);
  endtask
  initial begin
    step();
    step();
    check("rst_a_ready", a_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_last", r_last, 0);
    check("rst_r_data", r_data, 0);
    check("rst_ids", {b_id, r_id}, 0);
    check("rst_resps", {b_resp, r_resp}, 0);
    rst = 1'b0;
    #1;
    check("a_ready_release", a_ready, 1);
    wr(4'd0, 3'd4, 2'b01, 0);
    wr(4'd5, 3'd4, 2'b01, 2);
    wr(4'd9, 3'd2, 2'b01, 0);
    rd(4'd0, 32'h0, 8'd1, 3'd4, 2'b01, -1);
    rd(4'd3, 32'h20, 8'd1, 3'd4, 2'b01, -1);
    rd(4'd7, 32'h100, 8'd3, 3'd4, 2'b01, 1);
    rd(4'd1, 32'hFFFF_FFF0, 8'd1, 3'd4, 2'b01, -1);
    rd(4'd2, 32'h40, 8'd1, 3'd4, 2'b00, -1);
    rd(4'd4, 32'h8, 8'd2, 3'd2, 2'b01, -1);
    rd(4'd6, 32'h0, 8'd0, 3'd4, 2'b10, -1);
    issue(1'b0, 4'd8, 32'h200, 8'd3, 3'd4, 2'b01);
    r_ready = 1'b1;
    step();
    check("mid_burst_data", r_data, {4{32'h210}});
    rst = 1'b1;
    step();
    r_ready = 1'b0;
    check("abort_r_valid", r_valid, 0);
    check("abort_a_ready", a_ready, 0);
    check("abort_r_data", r_data, 0);
    rst = 1'b0;
    #1;
    check("abort_idle", a_ready, 1);
    rd(4'd0, 32'h0, 8'd0, 3'd4, 2'b01, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule
